baud_tick_gen: RTL and testbench

- Parametrised baud/oversample tick generator for the UART TX and RX datapaths.
- Prescaler period and oversample factor are generic; TX and RX run independent phase counters from one shared active divisor.
- RX phase can be re-aligned on start-bit detection, so `rx_sample` lands at a programmable point inside each bit.
- Divisor changes are shadowed and applied only on a TX bit boundary, so a running bit is never stretched or truncated.

---
 rtl/baud_tick_gen.sv | 109 ++++++++++
 tb/tb_baud_tick_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen.sv
// UART baud/oversample tick generator: independent TX and RX phase counters
// sharing one divisor that is shadowed and swapped only on a TX bit boundary.

module baud_phase_ctr #(
    parameter int DVSR_W = 11,
    parameter int OVS    = 16,
    parameter int OS_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DVSR_W-1:0] dvsr_act_i,
    output logic              os_tick_o,
    output logic [OS_W-1:0]   os_idx_o
);
    logic [DVSR_W-1:0] pre_q, pre_d;
    logic [OS_W-1:0]   os_q, os_d;

    // Equality against the divisor keeps D=all-ones safe: D+1 is never formed.
    assign os_tick_o = en_i && !rst && !clr_i && (pre_q == dvsr_act_i);
    assign os_idx_o  = os_q;

    always_comb begin
        pre_d = pre_q + DVSR_W'(1);
        os_d  = os_q;
        if (!en_i || clr_i) begin
            pre_d = '0;
            os_d  = '0;
        end else if (os_tick_o) begin
            pre_d = '0;
            os_d  = (os_q == OS_W'(OVS - 1)) ? '0 : os_q + OS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            os_q  <= '0;
        end else begin
            pre_q <= pre_d;
            os_q  <= os_d;
        end
    end
endmodule

module baud_tick_gen #(
    parameter int DVSR_W    = 11,
    parameter int OVS       = 16,
    parameter int SAMPLE_PT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              rx_resync,
    output logic              tx_os_tick,
    output logic              tx_tick,
    output logic              rx_os_tick,
    output logic              rx_sample,
    output logic [DVSR_W-1:0] dvsr_act
);
    localparam int OS_W    = $clog2(OVS);
    localparam int N_PATHS = 2;   // path 0 = TX, path 1 = RX

    logic [N_PATHS-1:0]           path_clr;
    logic [N_PATHS-1:0]           path_tick;
    logic [N_PATHS-1:0][OS_W-1:0] path_os;
    logic [DVSR_W-1:0]            dvsr_act_q, dvsr_act_d;

    // Only RX can be re-phased; TX runs free from enable.
    assign path_clr = {rx_resync, 1'b0};

    for (genvar p = 0; p < N_PATHS; p++) begin : g_path
        baud_phase_ctr #(
            .DVSR_W(DVSR_W),
            .OVS   (OVS),
            .OS_W  (OS_W)
        ) u_ctr (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en),
            .clr_i     (path_clr[p]),
            .dvsr_act_i(dvsr_act_q),
            .os_tick_o (path_tick[p]),
            .os_idx_o  (path_os[p])
        );
    end

    assign tx_os_tick = path_tick[0];
    assign tx_tick    = path_tick[0] && (path_os[0] == OS_W'(OVS - 1));
    assign rx_os_tick = path_tick[1];
    assign rx_sample  = path_tick[1] && (path_os[1] == OS_W'(SAMPLE_PT));
    assign dvsr_act   = dvsr_act_q;

    // Divisor tracks the input while idle, else swaps only at a TX bit edge.
    always_comb begin
        dvsr_act_d = dvsr_act_q;
        if (!en || tx_tick)
            dvsr_act_d = dvsr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dvsr_act_q <= '0;
        else
            dvsr_act_q <= dvsr_act_d;
    end
endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: per-cycle expectations from an arithmetic phase model
// go into a queue; a negedge monitor pops and compares them against the DUT.

module tb_baud_tick_gen;
    localparam int W   = 11;
    localparam int OVS = 16;
    localparam int SP  = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         rx_resync = 1'b0;
    logic [W-1:0] dvsr = '0;
    logic         tx_os_tick, tx_tick, rx_os_tick, rx_sample;
    logic [W-1:0] dvsr_act;

    baud_tick_gen #(.DVSR_W(W), .OVS(OVS), .SAMPLE_PT(SP)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dvsr      (dvsr),
        .rx_resync (rx_resync),
        .tx_os_tick(tx_os_tick),
        .tx_tick   (tx_tick),
        .rx_os_tick(rx_os_tick),
        .rx_sample (rx_sample),
        .dvsr_act  (dvsr_act)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [3:0]   ticks;   // {tx_os_tick, tx_tick, rx_os_tick, rx_sample}
        logic [W-1:0] act;
        bit           rx_chk;
    } exp_t;

    exp_t q[$];
    int   tx_log[$];
    int   rx_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Model: each path is "cycles elapsed since its phase origin" plus the
    // oversample index it had at that origin; ticks follow from div/mod.
    int m_d = 0, tx_e = 0, tx_b = 0, rx_e = 0, rx_b = 0;
    bit rx_known = 1'b1;

    task automatic step(input bit e, input bit r, input bit rs, input logic [W-1:0] dv);
        exp_t x;
        int   p, ti, ri;
        bit   to, tt, ro, rsm;
        @(posedge clk);
        #1;
        en = e; rst = r; rx_resync = rs; dvsr = dv;
        x.cyc = cyc; x.rx_chk = 1'b1;
        to = 0; tt = 0; ro = 0; rsm = 0; ri = 0;
        if (r) begin
            x.act = '0;
            m_d = 0; tx_e = 0; tx_b = 0; rx_e = 0; rx_b = 0; rx_known = 1'b1;
        end else if (!e) begin
            x.act = W'(m_d);
            m_d = int'(dv); tx_e = 0; tx_b = 0; rx_e = 0; rx_b = 0; rx_known = 1'b1;
        end else begin
            x.act = W'(m_d);
            p  = m_d + 1;
            to = (tx_e % p) == m_d;
            ti = (tx_b + tx_e / p) % OVS;
            tt = to && (ti == OVS - 1);
            if (!rs) begin
                ro  = (rx_e % p) == m_d;
                ri  = (rx_b + rx_e / p) % OVS;
                rsm = ro && (ri == SP);
                x.rx_chk = rx_known;
            end
            tx_e++; rx_e++;
            if (rs) begin
                rx_e = 0; rx_b = 0; rx_known = 1'b1;
            end
            if (tt) begin
                tx_e = 0; tx_b = 0;
                if (!rs && rx_known) begin
                    if (ro) begin
                        rx_b = (ri + 1) % OVS; rx_e = 0;
                    end else if (int'(dv) != m_d) begin
                        rx_known = 1'b0;   // RX mid-count under a new divisor
                    end
                end
                m_d = int'(dv);
            end
        end
        x.ticks = {to, tt, ro, rsm};
        q.push_back(x);
        cyc++;
    endtask

    exp_t       mx;
    logic [3:0] ma, mm;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mx = q.pop_front();
            ma = {tx_os_tick, tx_tick, rx_os_tick, rx_sample};
            mm = mx.rx_chk ? 4'hF : 4'hC;
            checks++;
            if (((ma & mm) !== (mx.ticks & mm)) || (dvsr_act !== mx.act)) begin
                errors++;
                $display("FAIL cycle %0d: ticks=%b dvsr_act=%0d, expected ticks=%b dvsr_act=%0d (mask %b)",
                         mx.cyc, ma, dvsr_act, mx.ticks, mx.act, mm);
            end
            if (tx_tick === 1'b1) tx_log.push_back(mx.cyc);
            if (rx_sample === 1'b1) rx_log.push_back(mx.cyc);
        end
    end

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", n, a, e);
        end
    endtask

    task automatic chk_log(input string n, input int lg[$], input int t0, input int e[$]);
        chk({n, " count"}, lg.size(), e.size());
        for (int i = 0; i < e.size() && i < lg.size(); i++)
            chk(n, lg[i] - t0, e[i]);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_start(input logic [W-1:0] dv, input int n, output int t0);
        tx_log.delete();
        rx_log.delete();
        for (int i = 0; i < n; i++) step(0, 0, 0, dv);
        t0 = cyc;
    endtask

    initial begin
        int  t0;
        bit  ren;
        logic [W-1:0] rdv;

        step(0, 1, 0, W'(3));
        #1;
        chk("reset outputs", int'({tx_os_tick, tx_tick, rx_os_tick, rx_sample}), 0);
        chk("reset dvsr_act", int'(dvsr_act), 0);
        step(0, 1, 0, W'(3));

        // basic timing
        idle_start(W'(3), 2, t0);
        for (int i = 0; i < 192; i++) step(1, 0, 0, W'(3));
        drain();
        chk_log("basic tx_tick", tx_log, t0, '{63, 127, 191});
        chk_log("basic rx_sample", rx_log, t0, '{31, 95, 159});
        chk("basic dvsr_act", int'(dvsr_act), 3);

        // RX resync at cycle 10
        idle_start(W'(3), 2, t0);
        for (int i = 0; i < 192; i++) step(1, 0, i == 10, W'(3));
        drain();
        chk_log("resync tx_tick", tx_log, t0, '{63, 127, 191});
        chk_log("resync rx_sample", rx_log, t0, '{42, 106, 170});

        // minimum divisor
        idle_start(W'(0), 2, t0);
        for (int i = 0; i < 48; i++) step(1, 0, i == 4, W'(0));
        drain();
        chk_log("d0 tx_tick", tx_log, t0, '{15, 31, 47});
        chk_log("d0 rx_sample", rx_log, t0, '{12, 28, 44});

        // divisor change mid-bit
        idle_start(W'(3), 2, t0);
        for (int i = 0; i < 192; i++) step(1, 0, 0, (i < 20) ? W'(3) : W'(7));
        drain();
        chk_log("dchg tx_tick", tx_log, t0, '{63, 191});
        chk("dchg dvsr_act", int'(dvsr_act), 7);

        // enable drop at 40..49, resync colliding with the sample at 31
        idle_start(W'(3), 2, t0);
        for (int i = 0; i < 114; i++) step(!(i >= 40 && i < 50), 0, i == 31, W'(3));
        drain();
        chk_log("endrop tx_tick", tx_log, t0, '{113});
        chk_log("endrop rx_sample", rx_log, t0, '{81});

        // async reset on a cycle that would carry a tx_os_tick
        idle_start(W'(3), 2, t0);
        for (int i = 0; i < 27; i++) step(1, 0, 0, W'(3));
        step(1, 1, 0, W'(3));
        #1;
        chk("async rst ticks", int'({tx_os_tick, tx_tick, rx_os_tick, rx_sample}), 0);
        chk("async rst dvsr_act", int'(dvsr_act), 0);
        step(1, 1, 0, W'(3));
        idle_start(W'(3), 1, t0);
        for (int i = 0; i < 192; i++) step(1, 0, 0, W'(3));
        drain();
        chk_log("post-rst tx_tick", tx_log, t0, '{63, 127, 191});
        chk_log("post-rst rx_sample", rx_log, t0, '{31, 95, 159});

        // maximum divisor
        idle_start(W'(2047), 1, t0);
        for (int i = 0; i < 32770; i++) step(1, 0, 0, W'(2047));
        drain();
        chk_log("dmax tx_tick", tx_log, t0, '{32767});
        chk("dmax dvsr_act", int'(dvsr_act), 2047);

        // randomized traffic
        ren = 1'b1;
        rdv = W'($urandom_range(0, 12));
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 199) == 0) ren = !ren;
            if ($urandom_range(0, 19) == 0) rdv = W'($urandom_range(0, 12));
            step(ren, $urandom_range(0, 1999) == 0, $urandom_range(0, 99) < 3, rdv);
        end
        drain();
        chk("queue drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
